cv32e40x_ex_wb_buf: RTL and testbench
=====================================

# cv32e40x_ex_wb_buf

EX-to-WB result buffer that sits directly downstream of the serial divider and the ALU. It accepts one result per handshake from whichever unit is finishing the current EX instruction. It tags each result with the register-file write address and enable, and holds up to two entries in order so that WB back-pressure never stalls a finished divide. Its source-side ready for the divider is what the divider samples as its output-side `ready_i`.

## Interface
Parameters:
- `DEPTH`, 2: number of entries; only 2 is supported.

Ports (clock and reset first):
- `clk` input 1: single clock; all flops on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `div_valid_i` input 1: divider result valid.
- `div_result_i` input 32: divider result.
- `div_ready_o` output 1: buffer accepts divider result; drives the divider's `ready_i`.
- `alu_valid_i` input 1: ALU result valid.
- `alu_result_i` input 32: ALU result.
- `alu_ready_o` output 1: buffer accepts ALU result.
- `rf_waddr_i` input 5: destination register of the current EX instruction.
- `rf_we_i` input 1: register-file write enable of the current EX instruction.
- `halt_i` input 1: controller halt; freezes the buffer.
- `kill_i` input 1: controller kill; flushes the buffer.
- `wb_valid_o` output 1: head entry valid to WB.
- `wb_ready_i` input 1: WB accepts the head entry.
- `wb_result_o` output 32: head result.
- `wb_rf_waddr_o` output 5: head destination register.
- `wb_rf_we_o` output 1: head write enable.
- `wb_src_o` output 1: head source tag (`EX_SRC_ALU`/`EX_SRC_DIV`).

## Operation
- State is the entry count, encoded as `EXWB_EMPTY`, `EXWB_ONE` or `EXWB_FULL`. Entries are stored in a head/tail pair (`e0` = head, `e1` = skid).
- Source arbitration:
  - Divider has priority.
  - `div_ready_o = !full && !halt_i`.
  - `alu_ready_o = !full && !halt_i && !div_valid_i`.
  - Both valid in one cycle is a protocol violation. The divider wins and the bench flags it with an assertion.
- Push occurs on `(div_valid_i && div_ready_o) || (alu_valid_i && alu_ready_o)`, with `!kill_i`.
- Each entry stores {result, `rf_waddr_i`, `rf_we_i`, src}.
- Pop occurs on `wb_valid_o && wb_ready_i`.
- Transitions:
  - EMPTY: push → ONE.
  - ONE: push only → FULL; pop only → EMPTY; push and pop → ONE (new entry becomes head).
  - FULL: pop → ONE (skid moves to head). Push is impossible because ready is low.
- Ready depends only on registered count, halt and kill. There is no combinational path from `wb_ready_i` to either source ready.
- `halt_i=1`:
  - No push and no pop.
  - `wb_valid_o=0`, `div_ready_o=0`, `alu_ready_o=0`.
  - All flops hold.
- `kill_i=1`:
  - Overrides halt.
  - Next state is EMPTY and both entries are invalidated.
  - `div_ready_o=1` and `alu_ready_o=1`, matching the divider's kill behaviour.
  - `wb_valid_o=0`; no push or pop is counted.
- Entry data payloads need not be cleared on kill; only the validity/count is reset.

## Timing
- Reset values:
  - Count is EMPTY and entry payloads are 0.
  - `wb_valid_o=0`; `wb_result_o`, `wb_rf_waddr_o`, `wb_rf_we_o` and `wb_src_o` are all 0.
  - `div_ready_o=1` and `alu_ready_o=1` (while `halt_i=0`).
- Latency: result pushed in cycle N is presented with `wb_valid_o=1` in cycle N+1.
- Throughput: one result per cycle when `wb_ready_i` is held high.
- Back-pressure: with `wb_ready_i=0`, two results are absorbed. Sources see ready low from the cycle after the second push.
- Ordering: strictly FIFO.
- WB outputs are driven from the head register only and stay stable while `wb_valid_o && !wb_ready_i`.
- Reset asserted mid-operation clears the count asynchronously; `wb_valid_o` falls immediately.

## Structure
- Shared package `cv32e40x_pkg` gains:
  - enum `ex_src_e` {`EX_SRC_ALU`, `EX_SRC_DIV`};
  - enum `exwb_state_e` {`EXWB_EMPTY`, `EXWB_ONE`, `EXWB_FULL`};
  - struct `ex_wb_entry_t` {result[31:0], rf_waddr[4:0], rf_we, src}.
- One sub-module is natural: `cv32e40x_skid_fifo2`, a 2-entry type-agnostic FIFO with flush. The top level contains the arbitration, the halt/kill gating and the field mapping.

## Test plan
- Single divide: `div_valid_i=1`, `div_result_i=32'hFFFF_FFFE`, `rf_waddr_i=5'd10`, `rf_we_i=1`, `wb_ready_i=1`. Expect the next cycle: `wb_valid_o=1`, `wb_result_o=32'hFFFF_FFFE`, `wb_rf_waddr_o=10`, `wb_src_o=EX_SRC_DIV`. Expect one cycle after that: `wb_valid_o=0`.
- Back-pressure: `wb_ready_i=0`; push ALU 32'h1 (x1), then DIV 32'h2 (x2).
  - Expect `div_ready_o=0` and `alu_ready_o=0` from the cycle after the second push.
  - Raise `wb_ready_i`; expect 32'h1 then 32'h2 in consecutive cycles.
  - Expect ready high the cycle after the first pop.
- Simultaneous source valid: `div_valid_i=1` with `div_result_i=7`, and `alu_valid_i=1` with `alu_result_i=9`. Expect `alu_ready_o=0`, only 7 enqueued, and the protocol assertion to fire.
- Halt: buffer in ONE holding 32'h55, then `halt_i=1` for 3 cycles with `wb_ready_i=1`. Expect `wb_valid_o=0`, both readies 0, and the entry retained. After halt drops, expect 32'h55 delivered.
- Kill while FULL: expect the next cycle EMPTY, `wb_valid_o=0`, and both readies 1. A new DIV result 32'h3 pushed afterwards is the only entry delivered.
- Async reset while ONE: deassert `rst_n` mid-cycle. Expect `wb_valid_o=0` immediately, and all WB outputs 0 until the first post-reset push.

Source files
------------

// File: rtl/cv32e40x_pkg.sv
// Shared types for the EX-to-WB result buffer: source tag, occupancy state
// and the buffered entry layout.
package cv32e40x_pkg;

  typedef enum logic {
    EX_SRC_ALU = 1'b0,
    EX_SRC_DIV = 1'b1
  } ex_src_e;

  typedef enum logic [1:0] {
    EXWB_EMPTY = 2'd0,
    EXWB_ONE   = 2'd1,
    EXWB_FULL  = 2'd2
  } exwb_state_e;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rf_waddr;
    logic        rf_we;
    ex_src_e     src;
  } ex_wb_entry_t;

  // Occupancy count; the state encoding is chosen to equal it.
  function automatic logic [1:0] exwb_cnt(exwb_state_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/cv32e40x_ex_wb_buf_if.sv
// EX-to-WB buffer bus: the two result sources, controller halt/kill and the WB side.
interface cv32e40x_ex_wb_buf_if;
  import cv32e40x_pkg::*;

  logic        div_valid_i;
  logic [31:0] div_result_i;
  logic        div_ready_o;
  logic        alu_valid_i;
  logic [31:0] alu_result_i;
  logic        alu_ready_o;
  logic [4:0]  rf_waddr_i;
  logic        rf_we_i;
  logic        halt_i;
  logic        kill_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [31:0] wb_result_o;
  logic [4:0]  wb_rf_waddr_o;
  logic        wb_rf_we_o;
  ex_src_e     wb_src_o;

  // master: the EX stage, controller and WB stage around the buffer
  modport master (
    output div_valid_i, div_result_i, alu_valid_i, alu_result_i,
           rf_waddr_i, rf_we_i, halt_i, kill_i, wb_ready_i,
    input  div_ready_o, alu_ready_o, wb_valid_o, wb_result_o,
           wb_rf_waddr_o, wb_rf_we_o, wb_src_o
  );

  modport slave (
    input  div_valid_i, div_result_i, alu_valid_i, alu_result_i,
           rf_waddr_i, rf_we_i, halt_i, kill_i, wb_ready_i,
    output div_ready_o, alu_ready_o, wb_valid_o, wb_result_o,
           wb_rf_waddr_o, wb_rf_we_o, wb_src_o
  );
endinterface

// File: rtl/cv32e40x_skid_fifo2.sv
// Two-entry in-order FIFO (head e0, skid e1) with flush; payload type is a parameter.
module cv32e40x_skid_fifo2
  import cv32e40x_pkg::*;
#(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic push_i,
  input  logic pop_i,
  input  T     din_i,
  output T     head_o,
  output logic valid_o,
  output logic full_o
);
  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  exwb_state_e state_q, state_d;
  T            e0_q, e1_q;
  logic        ld_e0, ld_e1, e0_from_e1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EXWB_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ld_e0      = 1'b0;
    ld_e1      = 1'b0;
    e0_from_e1 = 1'b0;
    case (state_q)
      EXWB_EMPTY: if (push_i) begin
        state_d = EXWB_ONE;
        ld_e0   = 1'b1;
      end
      EXWB_ONE: begin
        if (push_i && pop_i) begin
          ld_e0 = 1'b1;          // new entry replaces the departing head
        end else if (push_i) begin
          state_d = EXWB_FULL;
          ld_e1   = 1'b1;
        end else if (pop_i) begin
          state_d = EXWB_EMPTY;
        end
      end
      EXWB_FULL: if (pop_i) begin
        state_d    = EXWB_ONE;
        ld_e0      = 1'b1;
        e0_from_e1 = 1'b1;
      end
      default: state_d = EXWB_EMPTY;
    endcase
    if (flush_i) begin
      state_d = EXWB_EMPTY;
      ld_e0   = 1'b0;
      ld_e1   = 1'b0;
    end
  end

  // Payloads are only reset, never cleared on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q <= '0;
      e1_q <= '0;
    end else begin
      if (ld_e0) e0_q <= e0_from_e1 ? e1_q : din_i;
      if (ld_e1) e1_q <= din_i;
    end
  end

  assign head_o  = e0_q;
  assign valid_o = (state_q != EXWB_EMPTY);
  assign full_o  = (exwb_cnt(state_q) == FULL_CNT);
endmodule

// File: rtl/cv32e40x_ex_wb_buf.sv
// EX-to-WB result buffer: divider-priority source arbitration, halt/kill gating
// and entry tagging in front of a 2-entry skid FIFO.
module cv32e40x_ex_wb_buf
  import cv32e40x_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cv32e40x_ex_wb_buf_if.slave  bus
);
  ex_wb_entry_t din, head;
  logic         full, valid, push, pop;

  // Readies see only registered occupancy plus halt/kill, never wb_ready_i.
  assign bus.div_ready_o = bus.kill_i || (!full && !bus.halt_i);
  assign bus.alu_ready_o = bus.kill_i || (!full && !bus.halt_i && !bus.div_valid_i);

  assign push = !bus.kill_i &&
                ((bus.div_valid_i && bus.div_ready_o) || (bus.alu_valid_i && bus.alu_ready_o));
  assign bus.wb_valid_o = valid && !bus.halt_i && !bus.kill_i;
  assign pop            = bus.wb_valid_o && bus.wb_ready_i;

  always_comb begin
    din          = '0;
    din.result   = bus.div_valid_i ? bus.div_result_i : bus.alu_result_i;
    din.rf_waddr = bus.rf_waddr_i;
    din.rf_we    = bus.rf_we_i;
    din.src      = bus.div_valid_i ? EX_SRC_DIV : EX_SRC_ALU;
  end

  cv32e40x_skid_fifo2 #(
    .T     (ex_wb_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (bus.kill_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .head_o  (head),
    .valid_o (valid),
    .full_o  (full)
  );

  assign bus.wb_result_o   = head.result;
  assign bus.wb_rf_waddr_o = head.rf_waddr;
  assign bus.wb_rf_we_o    = head.rf_we;
  assign bus.wb_src_o      = head.src;
endmodule

// File: tb/tb_cv32e40x_ex_wb_buf.sv
// Directed bench for the EX-to-WB buffer: queue model checked every cycle,
// plus literal expectations from the worked scenarios.
module tb_cv32e40x_ex_wb_buf;
  import cv32e40x_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_viol = 0;

  cv32e40x_ex_wb_buf_if bus();

  cv32e40x_ex_wb_buf #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: a queue of at most two entries, updated from the rules on each edge.
  ex_wb_entry_t q[$];
  logic         clean = 1'b1;

  always @(negedge rst_n) begin
    q.delete();
    clean <= 1'b1;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      ex_wb_entry_t e;
      if (bus.div_valid_i && bus.alu_valid_i) n_viol++;
      if (bus.kill_i) q.delete();
      else if (!bus.halt_i) begin
        bit do_push;
        do_push = (bus.div_valid_i || bus.alu_valid_i) && (q.size() < 2);
        if (q.size() > 0 && bus.wb_ready_i) void'(q.pop_front());
        if (do_push) begin
          e.result   = bus.div_valid_i ? bus.div_result_i : bus.alu_result_i;
          e.rf_waddr = bus.rf_waddr_i;
          e.rf_we    = bus.rf_we_i;
          e.src      = bus.div_valid_i ? EX_SRC_DIV : EX_SRC_ALU;
          q.push_back(e);
          clean <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic ev, edr, ear;
      ev  = (q.size() > 0) && !bus.halt_i && !bus.kill_i;
      edr = bus.kill_i || (q.size() < 2 && !bus.halt_i);
      ear = bus.kill_i || (q.size() < 2 && !bus.halt_i && !bus.div_valid_i);
      chk("m_wb_valid",  32'(bus.wb_valid_o),  32'(ev));
      chk("m_div_ready", 32'(bus.div_ready_o), 32'(edr));
      chk("m_alu_ready", 32'(bus.alu_ready_o), 32'(ear));
      if (q.size() > 0 && ev) begin
        chk("m_result", bus.wb_result_o,          q[0].result);
        chk("m_waddr",  32'(bus.wb_rf_waddr_o),   32'(q[0].rf_waddr));
        chk("m_we",     32'(bus.wb_rf_we_o),      32'(q[0].rf_we));
        chk("m_src",    32'(bus.wb_src_o),        32'(q[0].src));
      end else if (clean) begin
        chk("m_rst_result", bus.wb_result_o,        32'h0);
        chk("m_rst_waddr",  32'(bus.wb_rf_waddr_o), 32'h0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.div_valid_i = 1'b0;
    bus.alu_valid_i = 1'b0;
  endtask

  task automatic push_div(input logic [31:0] r, input logic [4:0] a);
    bus.div_valid_i = 1'b1; bus.div_result_i = r; bus.rf_waddr_i = a; bus.rf_we_i = 1'b1;
    cyc(); idle();
  endtask

  task automatic push_alu(input logic [31:0] r, input logic [4:0] a);
    bus.alu_valid_i = 1'b1; bus.alu_result_i = r; bus.rf_waddr_i = a; bus.rf_we_i = 1'b1;
    cyc(); idle();
  endtask

  initial begin
    bus.div_valid_i = 0; bus.div_result_i = 0; bus.alu_valid_i = 0; bus.alu_result_i = 0;
    bus.rf_waddr_i = 0; bus.rf_we_i = 0; bus.halt_i = 0; bus.kill_i = 0; bus.wb_ready_i = 0;
    #1;
    chk("rst_valid",     32'(bus.wb_valid_o),  0);
    chk("rst_result",    bus.wb_result_o,      0);
    chk("rst_div_ready", 32'(bus.div_ready_o), 1);
    chk("rst_alu_ready", 32'(bus.alu_ready_o), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // single divide, one-cycle latency
    bus.wb_ready_i = 1'b1;
    push_div(32'hFFFF_FFFE, 5'd10);
    chk("div_valid", 32'(bus.wb_valid_o),    1);
    chk("div_res",   bus.wb_result_o,        32'hFFFF_FFFE);
    chk("div_waddr", 32'(bus.wb_rf_waddr_o), 10);
    chk("div_src",   32'(bus.wb_src_o),      32'(EX_SRC_DIV));
    cyc();
    chk("div_drain", 32'(bus.wb_valid_o), 0);

    // back-pressure absorbs two, then drains in order
    bus.wb_ready_i = 1'b0;
    push_alu(32'h1, 5'd1);
    push_div(32'h2, 5'd2);
    chk("bp_div_ready", 32'(bus.div_ready_o), 0);
    chk("bp_alu_ready", 32'(bus.alu_ready_o), 0);
    chk("bp_head",      bus.wb_result_o,      32'h1);
    chk("bp_head_src",  32'(bus.wb_src_o),    32'(EX_SRC_ALU));
    bus.wb_ready_i = 1'b1;
    cyc();
    chk("bp_second",    bus.wb_result_o,      32'h2);
    chk("bp_ready_up",  32'(bus.div_ready_o), 1);
    cyc();
    chk("bp_empty",     32'(bus.wb_valid_o),  0);

    // both sources valid: divider wins
    bus.div_valid_i = 1'b1; bus.div_result_i = 32'd7;
    bus.alu_valid_i = 1'b1; bus.alu_result_i = 32'd9; bus.rf_waddr_i = 5'd3;
    #1 chk("sim_alu_ready", 32'(bus.alu_ready_o), 0);
    cyc(); idle();
    chk("sim_res", bus.wb_result_o, 32'd7);
    cyc();
    chk("sim_only_one", 32'(bus.wb_valid_o), 0);

    // halt freezes a held entry
    bus.wb_ready_i = 1'b0;
    push_alu(32'h55, 5'd4);
    bus.wb_ready_i = 1'b1; bus.halt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("halt_valid", 32'(bus.wb_valid_o), 0);
      chk("halt_ready", 32'(bus.div_ready_o | bus.alu_ready_o), 0);
      cyc();
    end
    bus.halt_i = 1'b0;
    #1 chk("halt_release", bus.wb_result_o, 32'h55);
    chk("halt_rel_valid", 32'(bus.wb_valid_o), 1);
    cyc();
    chk("halt_drained", 32'(bus.wb_valid_o), 0);

    // kill while full
    bus.wb_ready_i = 1'b0;
    push_div(32'hA, 5'd6);
    push_alu(32'hB, 5'd7);
    bus.kill_i = 1'b1;
    #1 chk("kill_ready", 32'(bus.div_ready_o & bus.alu_ready_o), 1);
    chk("kill_valid", 32'(bus.wb_valid_o), 0);
    cyc();
    bus.kill_i = 1'b0;
    #1 chk("kill_empty", 32'(bus.wb_valid_o), 0);
    chk("kill_ready_after", 32'(bus.alu_ready_o), 1);
    bus.wb_ready_i = 1'b1;
    push_div(32'h3, 5'd8);
    chk("kill_new", bus.wb_result_o, 32'h3);
    cyc();
    chk("kill_only_one", 32'(bus.wb_valid_o), 0);

    // async reset while holding one entry
    bus.wb_ready_i = 1'b0;
    push_div(32'h77, 5'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",  32'(bus.wb_valid_o),    0);
    chk("arst_result", bus.wb_result_o,        0);
    chk("arst_waddr",  32'(bus.wb_rf_waddr_o), 0);
    chk("arst_we",     32'(bus.wb_rf_we_o),    0);
    chk("arst_src",    32'(bus.wb_src_o),      0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("arst_hold", bus.wb_result_o, 0);

    chk("protocol_violations", 32'(n_viol), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
